// File: rtl/stack_ctrl_pkg.sv
// Shared processor definitions for the call/return stack controller:
// default datapath/stack sizing and the controller's state encoding.
package stack_ctrl_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUSH   = 3'd1,
    POP    = 3'd2,
    SETTLE = 3'd3,
    FAULT  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/stack_ctrl.sv
// CALL/RET sequencer: drives an external hardware stack and reloads the PC.
// Every output is registered straight from the single state machine below.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             call_req,
  input  logic             ret_req,
  input  logic [WIDTH-1:0] ret_addr,
  input  logic [WIDTH-1:0] target,
  output logic             busy,
  output logic             done,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_out,
  output logic             fault_ovf,
  output logic             fault_unf,
  output logic             stk_c,
  output logic             stk_en,
  output logic [WIDTH-1:0] stk_push,
  input  logic [WIDTH-1:0] stk_peek,
  input  logic             stk_full,
  input  logic             stk_not_empty
);

  // The stack itself is sized by DEPTH; this block only needs it to be sane.
  if (DEPTH < 1) begin : g_bad_depth
    $error("stack_ctrl: DEPTH must be at least 1");
  end

  ctrl_state_t      state_reg;
  logic [WIDTH-1:0] jump_reg;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg <= IDLE;
      jump_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pc_load   <= 1'b0;
      pc_out    <= '0;
      fault_ovf <= 1'b0;
      fault_unf <= 1'b0;
      stk_c     <= 1'b0;
      stk_en    <= 1'b0;
      stk_push  <= '0;
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      done    <= 1'b0;
      pc_load <= 1'b0;
      stk_en  <= 1'b0;
      stk_c   <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (call_req) begin
            busy <= 1'b1;
            if (stk_full) begin
              fault_ovf <= 1'b1;
              done      <= 1'b1;
              state_reg <= FAULT;
            end else begin
              stk_push  <= ret_addr;
              jump_reg  <= target;
              stk_en    <= 1'b1;
              stk_c     <= 1'b1;
              state_reg <= PUSH;
            end
          end else if (ret_req) begin
            busy <= 1'b1;
            if (!stk_not_empty) begin
              fault_unf <= 1'b1;
              done      <= 1'b1;
              state_reg <= FAULT;
            end else begin
              // Capture the top now; it is gone once the pop is issued.
              jump_reg  <= stk_peek;
              stk_en    <= 1'b1;
              state_reg <= POP;
            end
          end
        end

        PUSH, POP: begin
          pc_load   <= 1'b1;
          pc_out    <= jump_reg;
          done      <= 1'b1;
          state_reg <= SETTLE;
        end

        SETTLE, FAULT: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a small stack beside the DUT, a queue-based model of
// the CALL/RET rules, directed scenarios followed by a randomized run.
module tb_stack_ctrl;

  localparam int W   = 8;
  localparam int D   = 1;
  localparam int CAP = 1 << D;

  logic         clk = 1'b0;
  logic         clr;
  logic         call_req, ret_req;
  logic [W-1:0] ret_addr, target;
  logic         busy, done, pc_load, fault_ovf, fault_unf, stk_c, stk_en;
  logic [W-1:0] pc_out, stk_push, stk_peek;
  logic         stk_full, stk_not_empty;

  always #5 clk = ~clk;

  stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .clr          (clr),
    .call_req     (call_req),
    .ret_req      (ret_req),
    .ret_addr     (ret_addr),
    .target       (target),
    .busy         (busy),
    .done         (done),
    .pc_load      (pc_load),
    .pc_out       (pc_out),
    .fault_ovf    (fault_ovf),
    .fault_unf    (fault_unf),
    .stk_c        (stk_c),
    .stk_en       (stk_en),
    .stk_push     (stk_push),
    .stk_peek     (stk_peek),
    .stk_full     (stk_full),
    .stk_not_empty(stk_not_empty)
  );

  // Stack instance beside the controller; cleared by ~clr.
  logic [W-1:0] env_mem [CAP];
  logic [D:0]   env_cnt;
  logic [D-1:0] idx_top;
  assign idx_top       = D'(env_cnt - 1'b1);
  assign stk_full      = env_cnt[D];
  assign stk_not_empty = |env_cnt;
  assign stk_peek      = stk_not_empty ? env_mem[idx_top] : '0;

  always_ff @(posedge clk) begin
    if (~clr) begin
      env_cnt <= '0;
    end else if (stk_en && stk_c && !stk_full) begin
      env_mem[env_cnt[D-1:0]] <= stk_push;
      env_cnt <= env_cnt + 1'b1;
    end else if (stk_en && !stk_c && stk_not_empty) begin
      env_cnt <= env_cnt - 1'b1;
    end
  end

  // Reference model
  logic [W-1:0] mq[$];
  bit           m_ovf, m_unf;
  logic [W-1:0] m_push;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic exp_cycle(input string tag, input bit b, input bit d, input bit pl,
                           input bit en, input bit c, input logic [W-1:0] pc_exp);
    chk({tag, ":busy"},    32'(busy),      32'(b));
    chk({tag, ":done"},    32'(done),      32'(d));
    chk({tag, ":pc_load"}, 32'(pc_load),   32'(pl));
    chk({tag, ":stk_en"},  32'(stk_en),    32'(en));
    chk({tag, ":stk_c"},   32'(stk_c),     32'(c));
    chk({tag, ":push"},    32'(stk_push),  32'(m_push));
    chk({tag, ":ovf"},     32'(fault_ovf), 32'(m_ovf));
    chk({tag, ":unf"},     32'(fault_unf), 32'(m_unf));
    if (pl) chk({tag, ":pc_out"}, 32'(pc_out), 32'(pc_exp));
  endtask

  task automatic check_stack(input string tag);
    chk({tag, ":not_empty"}, 32'(stk_not_empty), 32'(mq.size() != 0));
    chk({tag, ":full"},      32'(stk_full),      32'(mq.size() == CAP));
    if (mq.size() != 0) chk({tag, ":top"}, 32'(stk_peek), 32'(mq[$]));
  endtask

  task automatic do_reset(input string tag, input bit with_req);
    clr      = 1'b0;
    call_req = with_req;
    ret_req  = with_req;
    ret_addr = W'($urandom);
    target   = W'($urandom);
    @(posedge clk); #1;
    call_req = 1'b0;
    ret_req  = 1'b0;
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_push = '0;
    exp_cycle(tag, 0, 0, 0, 0, 0, '0);
    chk({tag, ":pc_out"}, 32'(pc_out), 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    exp_cycle({tag, "+1"}, 0, 0, 0, 0, 0, '0);
    check_stack(tag);
  endtask

  // One request from IDLE, followed through to IDLE again.
  task automatic txn(input string tag, input bit c, input bit r,
                     input logic [W-1:0] ra, input logic [W-1:0] tg, input bit hold_ret);
    bit           is_call, is_ret, fault;
    logic [W-1:0] exp_pc;
    is_call = c;
    is_ret  = !c && r;
    exp_pc  = '0;
    if (!is_call && !is_ret) begin
      @(posedge clk); #1;
      exp_cycle({tag, ":idle"}, 0, 0, 0, 0, 0, '0);
      return;
    end
    fault = is_call ? (mq.size() == CAP) : (mq.size() == 0);
    call_req = c;
    ret_req  = r;
    ret_addr = ra;
    target   = tg;
    @(posedge clk); #1;
    call_req = 1'b0;
    if (!hold_ret) ret_req = 1'b0;
    if (fault) begin
      if (is_call) m_ovf = 1'b1;
      else         m_unf = 1'b1;
      exp_cycle({tag, ":fault"}, 1, 1, 0, 0, 0, '0);
      @(posedge clk); #1;
      ret_req = 1'b0;
      exp_cycle({tag, ":idle"}, 0, 0, 0, 0, 0, '0);
    end else begin
      if (is_call) begin
        m_push = ra;
        exp_pc = tg;
      end else begin
        exp_pc = mq[$];
      end
      exp_cycle({tag, ":stk"}, 1, 0, 0, 1, is_call, '0);
      @(posedge clk); #1;
      ret_req = 1'b0;
      if (is_call) mq.push_back(ra);
      else         void'(mq.pop_back());
      exp_cycle({tag, ":settle"}, 1, 1, 1, 0, 0, exp_pc);
      @(posedge clk); #1;
      exp_cycle({tag, ":idle"}, 0, 0, 0, 0, 0, '0);
    end
    check_stack(tag);
  endtask

  initial begin
    clr = 1'b0; call_req = 1'b0; ret_req = 1'b0; ret_addr = '0; target = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_push = '0;

    do_reset("reset", 1'b1);
    txn("call21", 1, 0, 8'h21, 8'h80, 0);
    txn("ret21", 0, 1, 8'h00, 8'h00, 0);

    do_reset("reset2", 1'b0);
    txn("ret_empty", 0, 1, 8'h00, 8'h00, 0);
    txn("call_after_unf", 1, 0, 8'h33, 8'h90, 0);
    txn("ret_after_unf", 0, 1, 8'h00, 8'h00, 0);

    do_reset("reset3", 1'b0);
    txn("fill0", 1, 0, 8'h11, 8'h50, 0);
    txn("fill1", 1, 0, 8'h12, 8'h60, 0);
    txn("call_full", 1, 0, 8'h99, 8'h40, 0);
    txn("pop1", 0, 1, 8'h00, 8'h00, 0);

    txn("both", 1, 1, 8'h5a, 8'hc3, 1);
    txn("ret_hold", 0, 1, 8'h00, 8'h00, 1);

    // Reset landing in SETTLE, then in PUSH.
    call_req = 1'b1; ret_addr = 8'h44; target = 8'h77;
    @(posedge clk); #1;
    call_req = 1'b0;
    @(posedge clk); #1;
    chk("settle_pc_load", 32'(pc_load), 32'd1);
    clr = 1'b0;
    @(posedge clk); #1;
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_push = '0;
    exp_cycle("clr_settle", 0, 0, 0, 0, 0, '0);
    chk("clr_settle:pc_out", 32'(pc_out), 32'd0);
    clr = 1'b1;
    call_req = 1'b1; ret_addr = 8'h45; target = 8'h78;
    @(posedge clk); #1;
    call_req = 1'b0;
    clr = 1'b0;
    @(posedge clk); #1;
    mq.delete(); m_push = '0;
    exp_cycle("clr_push", 0, 0, 0, 0, 0, '0);
    clr = 1'b1;
    @(posedge clk); #1;
    exp_cycle("clr_push+1", 0, 0, 0, 0, 0, '0);
    check_stack("clr_push");

    for (int i = 0; i < 200; i++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if (op == 0)       do_reset("rnd_reset", 1'($urandom));
      else if (op < 9)   txn("rnd_call", 1, 0, W'($urandom), W'($urandom), 1'($urandom));
      else if (op < 17)  txn("rnd_ret", 0, 1, W'($urandom), W'($urandom), 1'($urandom));
      else if (op < 19)  txn("rnd_both", 1, 1, W'($urandom), W'($urandom), 1'($urandom));
      else               txn("rnd_none", 0, 0, '0, '0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data/address width; it matches the stack width.
REQ-002 SHALL have parameter DEPTH, default 1, meaning stack pointer bits; it matches the stack depth.
REQ-003 Reset: one clock; reset is synchronous and active-low (ports clk, clr).
REQ-004 Port list (name direction width meaning):
  clk  in  1  single clock, rising edge
  clr  in  1  synchronous active-low clear
  call_req  in  1  CALL request: push ret_addr, then jump to target
  ret_req  in  1  RET request: pop the top entry and jump to it
  ret_addr  in  WIDTH  return address to push (PC+1)
  target  in  WIDTH  CALL destination
  busy  out  1  high while a request is in progress
  done  out  1  one-cycle pulse when a request completes
  pc_load  out  1  one-cycle pulse that loads pc_out into the PC
  pc_out  out  WIDTH  new PC value, valid while pc_load=1
  fault_ovf  out  1  sticky flag: CALL was attempted while the stack was full
  fault_unf  out  1  sticky flag: RET was attempted while the stack was empty
  stk_c  out  1  stack control: 1=push, 0=pop
  stk_en  out  1  stack enable
  stk_push  out  WIDTH  data to push
  stk_peek  in  WIDTH  stack top
  stk_full  in  1  stack full
  stk_not_empty  in  1  stack non-empty

Function
REQ-005 SHALL implement an FSM with states IDLE, PUSH, POP, SETTLE, FAULT.
REQ-006 Requests SHALL be accepted only in IDLE; requests made while busy=1 are ignored and are not queued.
REQ-007 If call_req and ret_req are both high in IDLE, call_req SHALL win.
REQ-008 CALL accept when stk_full=0 (cycle N): latch ret_addr and target, then go to PUSH.
  - In N+1: stk_en=1, stk_c=1, stk_push=latched ret_addr; go to SETTLE.
  - In N+2: pc_load=1, pc_out=latched target, done=1; return to IDLE.
REQ-009 RET accept when stk_not_empty=1 (cycle N): latch stk_peek as the return address, then go to POP.
  - In N+1: stk_en=1, stk_c=0; go to SETTLE.
  - In N+2: pc_load=1, pc_out=latched address, done=1; return to IDLE.
REQ-010 CALL accepted with stk_full=1 SHALL:
  - set fault_ovf;
  - go to FAULT for one cycle, with no stk_en and no pc_load;
  - pulse done in that cycle, then return to IDLE.
REQ-011 RET accepted with stk_not_empty=0 SHALL behave the same as REQ-010, except that it sets fault_unf.
REQ-012 stk_en SHALL be high for exactly one cycle per successful request and low in every other state.
REQ-013 stk_c SHALL be 0 except in PUSH.
REQ-014 stk_push SHALL hold the last latched ret_addr.
REQ-015 busy SHALL be high in PUSH, POP, SETTLE and FAULT, and low in IDLE.
REQ-016 fault_ovf and fault_unf SHALL clear only on reset.
REQ-017 Throughput: at most one request per 3 cycles.
REQ-018 Latency: request to done is exactly 2 cycles.

Reset
REQ-019 When clr=0 at a rising clk edge, the block SHALL enter IDLE and drive all of the following to 0: busy, done, pc_load, pc_out, fault_ovf, fault_unf, stk_en, stk_c, stk_push, and the latched registers.
REQ-020 A reset in PUSH, POP or SETTLE SHALL abort the request with no done pulse and no pc_load.
REQ-021 The stack itself is cleared by its own active-high clr, which the top level drives as ~clr.
REQ-022 Requests presented while clr=0 SHALL be ignored.

Structure
REQ-023 The FSM state encoding (3-bit: IDLE=0, PUSH=1, POP=2, SETTLE=3, FAULT=4) SHALL live in the shared processor package.
REQ-024 The WIDTH and DEPTH defaults SHALL also live in the shared processor package.
REQ-025 SHALL contain no sub-module; the existing stack block is instantiated beside it at the processor top level.

Verification
REQ-026 After reset, CALL with ret_addr=0x21, target=0x80 -> stk_en/stk_c=1 and stk_push=0x21 one cycle later; then pc_load=1, pc_out=0x80, done=1 on the following cycle.
REQ-027 CALL (ret_addr=0x21), then RET -> RET pops, then pc_out=0x21 with pc_load=1; stk_not_empty drops to 0.
REQ-028 RET immediately after reset -> fault_unf=1, no stk_en, no pc_load, done=1; fault_unf stays 1 until clr=0.
REQ-029 With DEPTH=1, fill the stack until stk_full=1, then CALL target=0x40 -> fault_ovf=1, stack contents unchanged, no pc_load.
REQ-030 call_req and ret_req high together in IDLE -> CALL executes; ret_req high while busy -> ignored.
REQ-031 clr=0 asserted in SETTLE of a CALL -> next cycle IDLE, done=0, pc_load=0, all outputs 0.
